// File: rtl/cpu_pkg.sv
// Shared CPU definitions: mode encodings, memory width defaults and loader states.
// Used by the mode controller, the memory loader and the CPU control unit.
package cpu_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_IN    = 2'b01,
      MODE_CHECK = 2'b10,
      MODE_RUN   = 2'b11
   } mode_e;

   typedef enum logic {
      L_IDLE = 1'b0,
      L_WR   = 1'b1
   } ld_state_e;

endpackage

// File: rtl/mem_loader.sv
// Byte loader: accepts one byte in L_IDLE, writes it at load_addr during L_WR,
// then advances load_addr (wrapping at 2^AW).
module mem_loader
   import cpu_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          busy,
   output logic [AW-1:0] ld_addr,
   output logic [DW-1:0] ld_data,
   output logic          ld_write
);

   ld_state_e     state_r;
   ld_state_e     state_nx_s;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] data_r;
   logic          accept_s;

   assign in_ready = enable && (state_r == L_IDLE);
   assign accept_s = in_valid && in_ready;
   assign busy     = (state_r == L_WR);
   assign ld_write = (state_r == L_WR);
   assign ld_addr  = addr_r;
   assign ld_data  = data_r;

   // loader state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= L_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // loader next state: a write always lasts exactly one cycle
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         L_IDLE: begin
            if (accept_s) begin
               state_nx_s = L_WR;
            end else begin
               state_nx_s = L_IDLE;
            end
         end
         L_WR:    state_nx_s = L_IDLE;
         default: state_nx_s = L_IDLE;
      endcase
   end

   // load address: cleared on entry to IN, advanced after each write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r <= {AW{1'b0}};
      end else if (clr) begin
         addr_r <= {AW{1'b0}};
      end else if (state_r == L_WR) begin
         addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         addr_r <= addr_r;
      end
   end

   // byte latched on the accepting handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= {DW{1'b0}};
      end else if (accept_s) begin
         data_r <= in_data;
      end else begin
         data_r <= data_r;
      end
   end

endmodule

// File: rtl/cpu_mode_ctrl.sv
// CPU mode controller: IDLE/IN/CHECK/RUN mode FSM with deferred switching,
// memory check scanner and the shared memory port multiplexer.
module cpu_mode_ctrl
   import cpu_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    mode_sel,
   input  logic          mode_go,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic          chk_next,
   output logic [AW-1:0] chk_addr,
   output logic [DW-1:0] chk_data,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_dout,
   input  logic          cpu_read,
   input  logic          cpu_write,
   input  logic          cpu_iend,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_dout,
   output logic [1:0]    cpustate
);

   mode_e         mode_r, mode_nx_s;
   mode_e         tgt_r, tgt_nx_s;
   logic          pend_r, pend_nx_s;
   mode_e         sel_s, target_s;
   logic          req_s, want_s, can_s;
   logic          enter_in_s, enter_chk_s;
   logic          ld_enable_s, ld_busy_s, ld_write_s;
   logic [AW-1:0] ld_addr_s;
   logic [DW-1:0] ld_data_s;
   logic [AW-1:0] chk_addr_r;
   logic [DW-1:0] chk_data_r;

   assign sel_s       = mode_e'(mode_sel);
   assign cpustate    = mode_r;
   assign chk_addr    = chk_addr_r;
   assign chk_data    = chk_data_r;
   // a switch requested this very cycle must also block a new loader handshake
   assign ld_enable_s = (mode_r == MODE_IN) && !pend_r && !req_s;

   mem_loader #(.AW(AW), .DW(DW)) u_loader (
      .clk      (clk),
      .rst      (rst),
      .enable   (ld_enable_s),
      .clr      (enter_in_s),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (ld_busy_s),
      .ld_addr  (ld_addr_s),
      .ld_data  (ld_data_s),
      .ld_write (ld_write_s)
   );

   // mode, pending flag and pending target registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_r <= MODE_IDLE;
         tgt_r  <= MODE_IDLE;
         pend_r <= 1'b0;
      end else begin
         mode_r <= mode_nx_s;
         tgt_r  <= tgt_nx_s;
         pend_r <= pend_nx_s;
      end
   end

   // mode next state: a fresh request overrides any pending target
   always_comb begin
      mode_nx_s   = mode_r;
      tgt_nx_s    = tgt_r;
      pend_nx_s   = pend_r;
      enter_in_s  = 1'b0;
      enter_chk_s = 1'b0;
      req_s       = mode_go && (sel_s != mode_r);
      want_s      = req_s || pend_r;
      target_s    = req_s ? sel_s : tgt_r;
      case (mode_r)
         MODE_IDLE:  can_s = 1'b1;
         MODE_CHECK: can_s = 1'b1;
         MODE_IN:    can_s = !ld_busy_s;
         MODE_RUN:   can_s = cpu_iend;
         default:    can_s = 1'b0;
      endcase
      if (want_s && can_s) begin
         mode_nx_s   = target_s;
         pend_nx_s   = 1'b0;
         enter_in_s  = (target_s == MODE_IN);
         enter_chk_s = (target_s == MODE_CHECK);
      end else if (want_s) begin
         pend_nx_s = 1'b1;
         tgt_nx_s  = target_s;
      end else begin
         pend_nx_s = pend_r;
      end
   end

   // check address: cleared on entry to CHECK, stepped by chk_next only in CHECK
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_addr_r <= {AW{1'b0}};
      end else if (enter_chk_s) begin
         chk_addr_r <= {AW{1'b0}};
      end else if ((mode_r == MODE_CHECK) && chk_next) begin
         chk_addr_r <= chk_addr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         chk_addr_r <= chk_addr_r;
      end
   end

   // check data follows the addressed byte one cycle late
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_data_r <= {DW{1'b0}};
      end else if (mode_r == MODE_CHECK) begin
         chk_data_r <= mem_dout;
      end else begin
         chk_data_r <= chk_data_r;
      end
   end

   // shared memory port mux; the strobes are mutually exclusive per mode
   always_comb begin
      mem_addr  = {AW{1'b0}};
      mem_din   = {DW{1'b0}};
      mem_read  = 1'b0;
      mem_write = 1'b0;
      case (mode_r)
         MODE_IDLE: begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
         MODE_IN: begin
            mem_addr  = ld_addr_s;
            mem_din   = ld_data_s;
            mem_write = ld_write_s;
         end
         MODE_CHECK: begin
            mem_addr = chk_addr_r;
            mem_read = 1'b1;
         end
         MODE_RUN: begin
            mem_addr  = cpu_addr;
            mem_din   = cpu_dout;
            mem_read  = cpu_read && !cpu_write;
            mem_write = cpu_write;
         end
         default: begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_mode_ctrl.sv
// Self-checking bench for cpu_mode_ctrl: vector table for the mode/load/check flow,
// plus directed sequences for address wrap and asynchronous reset mid-write.
module tb_cpu_mode_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode_sel;
   logic        mode_go, in_valid, in_ready, chk_next;
   logic [7:0]  in_data, chk_data, cpu_dout, mem_din, mem_dout;
   logic [15:0] chk_addr, cpu_addr, mem_addr;
   logic        cpu_read, cpu_write, cpu_iend, mem_read, mem_write;
   logic [1:0]  cpustate;
   logic [7:0]  mem [0:65535];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        go;
      logic [1:0]  sel;
      logic        iend, iv;
      logic [7:0]  idata;
      logic        cnext, crd, cwr;
      logic [15:0] caddr;
      logic [7:0]  cdout;
      logic [1:0]  e_st;
      logic        e_rdy, e_mr, e_mw;
      logic [15:0] e_addr;
      logic [7:0]  e_din, e_chk;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   cpu_mode_ctrl #(.AW(16), .DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_sel  (mode_sel),
      .mode_go   (mode_go),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .chk_next  (chk_next),
      .chk_addr  (chk_addr),
      .chk_data  (chk_data),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_read  (cpu_read),
      .cpu_write (cpu_write),
      .cpu_iend  (cpu_iend),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_dout  (mem_dout),
      .cpustate  (cpustate)
   );

   assign mem_dout = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_din;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic go, input logic [1:0] sel, input logic iend,
                               input logic iv, input logic [7:0] idata, input logic cnext,
                               input logic crd, input logic cwr, input logic [15:0] caddr,
                               input logic [7:0] cdout, input logic [1:0] e_st,
                               input logic e_rdy, input logic e_mr, input logic e_mw,
                               input logic [15:0] e_addr, input logic [7:0] e_din,
                               input logic [7:0] e_chk);
      vec_t v;
      v.go = go; v.sel = sel; v.iend = iend; v.iv = iv; v.idata = idata;
      v.cnext = cnext; v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cdout = cdout;
      v.e_st = e_st; v.e_rdy = e_rdy; v.e_mr = e_mr; v.e_mw = e_mw;
      v.e_addr = e_addr; v.e_din = e_din; v.e_chk = e_chk;
      return v;
   endfunction

   task automatic idle_inputs();
      mode_go = 1'b0; mode_sel = 2'b00; in_valid = 1'b0; in_data = 8'h00;
      chk_next = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
      cpu_read = 1'b0; cpu_write = 1'b0; cpu_iend = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      idle_inputs();
      rst = 1'b1;

      //         go sel  iend iv  idata cn  rd  wr  caddr     cdout | st  rdy mr  mw  addr      din    chk
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd0, 0, 0, 0, 16'h0000, 8'h00, 8'h00));
      vecs.push_back(mk(1, 2'd1, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd0, 0, 0, 0, 16'h0000, 8'h00, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 1, 8'h11, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 1, 0, 0, 16'h0000, 8'h00, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 1, 8'h22, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 0, 0, 1, 16'h0000, 8'h11, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 1, 8'h22, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 1, 0, 0, 16'h0001, 8'h11, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 0, 0, 1, 16'h0001, 8'h22, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 1, 8'h33, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 1, 0, 0, 16'h0002, 8'h22, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 0, 0, 1, 16'h0002, 8'h33, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 1, 0, 0, 16'h0003, 8'h33, 8'h00));
      vecs.push_back(mk(1, 2'd2, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 0, 0, 0, 16'h0003, 8'h33, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd2, 0, 1, 0, 16'h0000, 8'h00, 8'h00));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00, 2'd2, 0, 1, 0, 16'h0000, 8'h00, 8'h11));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd2, 0, 1, 0, 16'h0001, 8'h00, 8'h11));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00, 2'd2, 0, 1, 0, 16'h0001, 8'h00, 8'h22));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd2, 0, 1, 0, 16'h0002, 8'h00, 8'h22));
      vecs.push_back(mk(1, 2'd2, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd2, 0, 1, 0, 16'h0002, 8'h00, 8'h33));
      vecs.push_back(mk(1, 2'd3, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd2, 0, 1, 0, 16'h0002, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 1, 0, 16'h1234, 8'h00, 2'd3, 0, 1, 0, 16'h1234, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 1, 16'h0005, 8'h5A, 2'd3, 0, 0, 1, 16'h0005, 8'h5A, 8'h33));
      vecs.push_back(mk(1, 2'd1, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 1, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 1, 0, 0, 16'h0000, 8'h33, 8'h33));
      vecs.push_back(mk(1, 2'd3, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd1, 0, 0, 0, 16'h0000, 8'h33, 8'h33));
      vecs.push_back(mk(1, 2'd0, 1, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd0, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(1, 2'd3, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd0, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(1, 2'd1, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(1, 2'd2, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 1, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd3, 0, 0, 0, 16'h0000, 8'h00, 8'h33));
      vecs.push_back(mk(0, 2'd0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 2'd2, 0, 1, 0, 16'h0000, 8'h00, 8'h33));

      // reset state
      repeat (2) @(negedge clk);
      check("rst_cpustate", cpustate, 2'd0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_mem_write", mem_write, 1'b0);
      check("rst_chk_addr", chk_addr, 16'h0000);
      check("rst_chk_data", chk_data, 8'h00);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         mode_go = vecs[i].go;   mode_sel = vecs[i].sel;  cpu_iend = vecs[i].iend;
         in_valid = vecs[i].iv;  in_data = vecs[i].idata; chk_next = vecs[i].cnext;
         cpu_read = vecs[i].crd; cpu_write = vecs[i].cwr; cpu_addr = vecs[i].caddr;
         cpu_dout = vecs[i].cdout;
         #1;
         check($sformatf("v%0d_cpustate", i), cpustate, vecs[i].e_st);
         check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_rdy);
         check($sformatf("v%0d_mem_read", i), mem_read, vecs[i].e_mr);
         check($sformatf("v%0d_mem_write", i), mem_write, vecs[i].e_mw);
         check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
         check($sformatf("v%0d_mem_din", i), mem_din, vecs[i].e_din);
         check($sformatf("v%0d_chk_data", i), chk_data, vecs[i].e_chk);
      end

      // check address wrap: step to 0xFFFF, then one more pulse
      @(negedge clk);
      idle_inputs();
      chk_next = 1'b1;
      repeat (65535) @(posedge clk);
      @(negedge clk);
      chk_next = 1'b0;
      #1;
      check("wrap_at_ffff", chk_addr, 16'hFFFF);
      @(negedge clk);
      chk_next = 1'b1;
      @(negedge clk);
      chk_next = 1'b0;
      #1;
      check("wrap_to_0000", chk_addr, 16'h0000);

      // asynchronous reset in the middle of a loader write
      @(negedge clk);
      mode_go = 1'b1; mode_sel = 2'b01;
      @(negedge clk);
      mode_go = 1'b0; in_valid = 1'b1; in_data = 8'h44;
      #1;
      check("pre_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("pre_rst_mem_write", mem_write, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_mem_write", mem_write, 1'b0);
      check("arst_mem_read", mem_read, 1'b0);
      check("arst_cpustate", cpustate, 2'd0);
      check("arst_in_ready", in_ready, 1'b0);
      check("arst_chk_data", chk_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_cpustate", cpustate, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
